// File: rtl/spi_adc_responder.sv
// SPI mode-0 responder emulating a 12-bit serial ADC: serves one padded sample per
// CS-low frame on miso and captures the initiator's mosi bits into rx_data.
module spi_adc_responder #(
  parameter int DATA_W      = 12,
  parameter int PAD_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         sample,
  input  logic                      sample_valid,
  input  logic                      sck,
  input  logic                      cs_n,
  input  logic                      mosi,
  output logic                      miso,
  output logic                      miso_oe,
  output logic [PAD_W+DATA_W-1:0]   rx_data,
  output logic                      rx_valid,
  output logic                      busy,
  output logic                      frame_abort
);

  localparam int FRAME_W = PAD_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state, state_nxt;
  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                 sck_d, cs_d;
  logic                 sck_s, cs_s, mosi_s;
  logic                 sck_rise, sck_fall, cs_rise, cs_fall;
  logic [DATA_W-1:0]    hold, hold_nxt;
  logic [FRAME_W-1:0]   tx, tx_nxt, rx, rx_nxt, rx_data_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt, cnt_inc;
  logic                 miso_nxt, rx_valid_nxt, abort_nxt;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign cnt_inc  = cnt + 1'b1;

  assign miso_oe  = (state != IDLE);
  assign busy     = (state != IDLE);

  // cs_n chain clears to low so a select already held low across reset
  // cannot look like a fresh fall; a frame needs cs_n to be seen high first.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync    <= '0;
      cs_sync     <= '0;
      mosi_sync   <= '0;
      sck_d       <= 1'b0;
      cs_d        <= 1'b0;
      state       <= IDLE;
      hold        <= '0;
      tx          <= '0;
      rx          <= '0;
      cnt         <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_abort <= 1'b0;
      miso        <= 1'b0;
    end else begin
      sck_sync    <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync     <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_d       <= sck_s;
      cs_d        <= cs_s;
      state       <= state_nxt;
      hold        <= hold_nxt;
      tx          <= tx_nxt;
      rx          <= rx_nxt;
      cnt         <= cnt_nxt;
      rx_data     <= rx_data_nxt;
      rx_valid    <= rx_valid_nxt;
      frame_abort <= abort_nxt;
      miso        <= miso_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    tx_nxt       = tx;
    rx_nxt       = rx;
    cnt_nxt      = cnt;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = 1'b0;
    abort_nxt    = 1'b0;
    miso_nxt     = miso;
    hold_nxt     = sample_valid ? sample : hold;

    case (state)
      IDLE: begin
        miso_nxt = 1'b0;
        if (cs_fall) begin
          // hold_nxt lets a sample arriving with the fall detect be served
          tx_nxt    = {{PAD_W{1'b0}}, hold_nxt};
          cnt_nxt   = '0;
          miso_nxt  = tx_nxt[FRAME_W-1];
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          abort_nxt = 1'b1;
          miso_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (sck_rise) begin
          rx_nxt  = {rx[FRAME_W-2:0], mosi_s};
          cnt_nxt = cnt_inc;
          if (cnt_inc == CNT_W'(FRAME_W)) begin
            rx_data_nxt  = rx_nxt;
            rx_valid_nxt = 1'b1;
            miso_nxt     = 1'b0;
            state_nxt    = DONE;
          end
        end else if (sck_fall) begin
          tx_nxt   = tx << 1;
          miso_nxt = tx[FRAME_W-2];
        end
      end
      DONE: begin
        miso_nxt = 1'b0;
        if (cs_rise) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
